// File: rtl/vending_sequencer.sv
// rtl/vending_sequencer.sv - vending front end: button debounce, coin credit, product cursor, purchase FSM
// Optional macro TIMEOUT_EN adds an inactivity timeout in SELECT that returns the credit.
module vending_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DISPENSE_CYCLES = 100000000,
  parameter int DENY_CYCLES     = 50000000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int COIN_VALUE      = 1,
  parameter int PRICE0          = 3,
  parameter int PRICE1          = 5,
  parameter int PRICE2          = 2,
  parameter int PRICE3          = 4
`ifdef TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 500000000
`endif
) (
  input  logic       clk_50,
  input  logic       reset_key,
  input  logic       b_left,
  input  logic       b_right,
  input  logic       b_coin,
  input  logic       start_key,
  output logic [1:0] sel_idx,
  output logic       sel_valid,
  output logic       blink,
  output logic [2:0] state,
  output logic [7:0] credit,
  output logic       dispense_valid,
  output logic [1:0] dispense_idx,
  output logic       change_valid,
  output logic [7:0] change_amt
);

  localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (DISPENSE_CYCLES > DENY_CYCLES) ? DISPENSE_CYCLES : DENY_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
`ifdef TIMEOUT_EN
  localparam int IW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_DENIED   = 3'd2,
    S_DISPENSE = 3'd3,
    S_CHANGE   = 3'd4
  } state_t;

  // Button lanes: 0 left, 1 right, 2 coin, 3 start
  logic [3:0]          raw, sync1, sync2, filt, press;
  logic [3:0][DBW-1:0] db_cnt;

  assign raw = {start_key, b_coin, b_right, b_left};

  always_ff @(posedge clk_50 or posedge reset_key) begin
    if (reset_key) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      press  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          filt[i]   <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'(PRICE0);
      2'd1:    return 8'(PRICE1);
      2'd2:    return 8'(PRICE2);
      default: return 8'(PRICE3);
    endcase
  endfunction

  state_t        st, st_n;
  logic [7:0]    credit_n, coin_credit;
  logic [8:0]    coin_sum;
  logic [1:0]    sel_n, disp_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [BW-1:0] blink_cnt;
`ifdef TIMEOUT_EN
  logic [IW-1:0] idle_cnt, idle_n;
`endif

  assign state    = st;
  assign coin_sum = {1'b0, credit} + 9'(COIN_VALUE);

  always_comb begin
    st_n        = st;
    sel_n       = sel_idx;
    disp_n      = dispense_idx;
    tmr_n       = tmr;
    coin_credit = credit;
`ifdef TIMEOUT_EN
    idle_n      = '0;
`endif
    // Coin is applied before start so a same-cycle start sees the new credit
    if (press[2] && st != S_CHANGE)
      coin_credit = coin_sum[8] ? 8'd255 : coin_sum[7:0];
    credit_n = coin_credit;

    case (st)
      S_IDLE: begin
        if (press[2]) st_n = S_SELECT;
      end
      S_SELECT: begin
        if (press[3]) begin
          tmr_n = '0;
          if (coin_credit >= price_of(sel_idx)) begin
            credit_n = coin_credit - price_of(sel_idx);
            disp_n   = sel_idx;
            st_n     = S_DISPENSE;
          end else begin
            st_n = S_DENIED;
          end
        end else if (press[0] && !press[1]) begin
          sel_n = sel_idx - 2'd1;
        end else if (press[1] && !press[0]) begin
          sel_n = sel_idx + 2'd1;
        end
`ifdef TIMEOUT_EN
        if (|press)
          idle_n = '0;
        else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1))
          st_n = S_CHANGE;
        else
          idle_n = idle_cnt + IW'(1);
`endif
      end
      S_DENIED: begin
        if (tmr == TW'(DENY_CYCLES - 1)) begin
          tmr_n = '0;
          st_n  = S_SELECT;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      S_DISPENSE: begin
        if (tmr == TW'(DISPENSE_CYCLES - 1)) begin
          tmr_n = '0;
          st_n  = (coin_credit != 8'd0) ? S_CHANGE : S_IDLE;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      S_CHANGE: begin
        credit_n = 8'd0;
        st_n     = S_IDLE;
      end
      default: st_n = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next-state view so they align with state
  always_ff @(posedge clk_50 or posedge reset_key) begin
    if (reset_key) begin
      st             <= S_IDLE;
      sel_idx        <= '0;
      credit         <= '0;
      dispense_idx   <= '0;
      tmr            <= '0;
      blink_cnt      <= '0;
      blink          <= 1'b0;
      sel_valid      <= 1'b0;
      dispense_valid <= 1'b0;
      change_valid   <= 1'b0;
      change_amt     <= '0;
`ifdef TIMEOUT_EN
      idle_cnt       <= '0;
`endif
    end else begin
      st             <= st_n;
      sel_idx        <= sel_n;
      credit         <= credit_n;
      dispense_idx   <= disp_n;
      tmr            <= tmr_n;
      sel_valid      <= (st_n == S_SELECT) || (st_n == S_DENIED);
      dispense_valid <= (st_n == S_DISPENSE);
      change_valid   <= (st_n == S_CHANGE);
      change_amt     <= (st_n == S_CHANGE) ? credit_n : 8'd0;
`ifdef TIMEOUT_EN
      idle_cnt       <= idle_n;
`endif
      if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule
